// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers h/v position from incoming syncs, checks timing and tracks lock
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state, state_nxt;
  logic hs_q, vs_q, hs_fall, hs_rise, vs_fall, vs_rise;
  logic h_last, v_last, line_end, sof, chk, err_any;
  logic [3:0] good, good_nxt;
  logic [9:0] h_nxt, v_nxt;
  assign hs_fall  = hs_q & ~hsync;
  assign hs_rise  = ~hs_q & hsync;
  assign vs_fall  = vs_q & ~vsync;
  assign vs_rise  = ~vs_q & vsync;
  assign h_last   = hcount == 10'(H_TOTAL - 1);
  assign v_last   = vcount == 10'(V_TOTAL - 1);
  assign line_end = hs_fall | h_last;
  assign sof      = hs_fall & vs_fall;
  assign chk      = state != SEARCH;
  assign h_nxt    = line_end ? '0 : hcount + 10'd1;
  assign v_nxt    = !line_end ? vcount : (sof | v_last) ? '0 : vcount + 10'd1;
  assign h_err = chk & ((hs_fall & ~h_last) | (h_last & ~hs_fall) |
                        (hs_rise & (hcount != 10'(H_SYNC - 1))));
  assign v_err = chk & (((vs_fall | vs_rise) & ~hs_fall) | (vs_fall & ~v_last) |
                        (line_end & v_last & ~vs_fall) |
                        (vs_rise & hs_fall & (vcount != 10'(V_SYNC - 1))));
  assign err_any = h_err | v_err;
  assign locked  = state == LOCKED;
  assign de = locked && hcount >= 10'(H_ACT_START) && hcount < 10'(H_ACT_END) &&
              vcount >= 10'(V_ACT_START) && vcount < 10'(V_ACT_END);
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    if (state == SEARCH) begin
      if (sof) begin
        state_nxt = ACQUIRE;
        good_nxt  = '0;
      end
    end else if (err_any) begin
      state_nxt = SEARCH;
    end else if (state == ACQUIRE && sof) begin
      good_nxt  = good + 4'd1;
      state_nxt = (good + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : ACQUIRE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcount      <= '0;
      vcount      <= '0;
      state       <= SEARCH;
      good        <= '0;
      frame_start <= 1'b0;
      err_cnt     <= '0;
    end else begin
      hs_q        <= hsync;
      vs_q        <= vsync;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      state       <= state_nxt;
      good        <= good_nxt;
      frame_start <= state_nxt != SEARCH && h_nxt == '0 && v_nxt == '0;
      if (err_any && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
